// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hF000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO holding fetched instructions with their PCs.
// The head entry is always slot 0, so head outputs come straight from flops.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [PC_W-1:0]    push_pc_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [1:0]         count_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [PC_W-1:0]    head_pc_o
);

    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic [PC_W-1:0]    head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = push_instr_i;
                        head_pc_d    = push_pc_i;
                    end else if (count_q == 2'd1) begin
                        tail_instr_d = push_instr_i;
                        tail_pc_d    = push_pc_i;
                    end
                    if (count_q != 2'd2) count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    if (count_q != 2'd0) count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy is unchanged.
                    if (count_q == 2'd2) begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = push_instr_i;
                        tail_pc_d    = push_pc_i;
                    end else begin
                        head_instr_d = push_instr_i;
                        head_pc_d    = push_pc_i;
                        count_d      = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign full_o       = (count_q == 2'd2);
    assign empty_o      = (count_q == 2'd0);
    assign count_o      = count_q;
    assign head_instr_o = head_instr_q;
    assign head_pc_o    = head_pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, one in-flight synchronous ROM read, 2-deep buffer.
// Halt detection on HALT_WORD is built only when IFETCH_HALT_DETECT_EN is defined.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    output logic               finished
);

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_e     state_q;
    logic [PC_W-1:0]  pc_q;
    logic             inflight_q;
    logic [PC_W-1:0]  inflight_pc_q;

    logic             fifo_full, fifo_empty;
    logic [1:0]       fifo_count;
    logic             xfer, halt_hit, redirect_hit, flush, issue;
    logic [2:0]       occ_after;

    assign xfer         = instr_valid && instr_ready;
    assign halt_hit     = HALT_EN && (state_q == ST_RUN) && xfer && (instr == HALT_WORD);
    assign redirect_hit = (state_q == ST_RUN) && redirect_valid && !halt_hit;
    assign flush        = halt_hit || redirect_hit;

    // Issue only if the returning word is guaranteed a free slot next edge.
    assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};
    assign issue     = (state_q == ST_RUN) && !flush && !(fifo_full && !xfer)
                       && (occ_after <= 3'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_hit) begin
                        state_q    <= ST_HALTED;
                        inflight_q <= 1'b0;
                    end else if (redirect_hit) begin
                        pc_q       <= redirect_pc;
                        inflight_q <= 1'b0;
                    end else begin
                        inflight_q <= issue;
                        if (issue) begin
                            inflight_pc_q <= pc_q;
                            pc_q          <= pc_q + PC_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    inflight_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (inflight_q),
        .pop_i        (xfer),
        .flush_i      (flush),
        .push_instr_i (rom_data),
        .push_pc_i    (inflight_pc_q),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .head_instr_o (instr),
        .head_pc_o    (instr_pc)
    );

    assign rom_addr    = pc_q[ADDR_W-1:0];
    assign instr_valid = !fifo_empty;
    assign finished    = HALT_EN && (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: synchronous ROM model plus a scoreboard queue.
// Halt behaviour is checked in the IFETCH_HALT_DETECT_EN build, pass-through otherwise.
module tb_instr_fetch;

    localparam logic [31:0] HALT = 32'hF000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        finished;

    logic [31:0] rom_mem [256];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .finished       (finished)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return rom_mem[pc[7:0]];
    endfunction

    task automatic push_range(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: first + 32'(i), ins: rom_word(first + 32'(i))});
        end
    endtask

    // Accepts n transfers, comparing each against the scoreboard head.
    task automatic drain(input int n, input bit hold, output int cycles);
        int   got = 0;
        exp_t e;
        cycles = 0;
        while (got < n && cycles < n * 4 + 20) begin
            @(negedge clk);
            cycles++;
            instr_ready = 1'b1;
            if (instr_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got pc=%0h instr=%0h, required none", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e.pc || instr !== e.ins) begin
                        errors++;
                        $display("FAIL xfer: got pc=%0h instr=%0h, required pc=%0h instr=%0h",
                                 instr_pc, instr, e.pc, e.ins);
                    end else begin
                        $display("txn pc=%0h instr=%0h", instr_pc, instr);
                    end
                end
                got++;
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d transfers, required %0d", got, n);
        end
        if (!hold) begin
            @(negedge clk);
            instr_ready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
        if (instr !== 32'h0)      begin errors++; $display("FAIL rst_instr: got %0h, required 0", instr); end
        if (instr_pc !== 32'h0)   begin errors++; $display("FAIL rst_pc: got %0h, required 0", instr_pc); end
        if (rom_addr !== 8'h0)    begin errors++; $display("FAIL rst_addr: got %0h, required 0", rom_addr); end
        if (finished !== 1'b0)    begin errors++; $display("FAIL rst_finished: got %b, required 0", finished); end
    endtask

    task automatic test_startup();
        int cyc;
        instr_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL start_edge1: got valid=%b, required 0", instr_valid); end
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL start_edge2: got valid=%b, required 1", instr_valid); end
        push_range(32'd0, 12);
        drain(12, 1'b0, cyc);
        checks++;
        if (cyc != 12) begin errors++; $display("FAIL throughput: got %0d cycles, required 12", cyc); end
    endtask

    task automatic test_stall();
        logic [31:0] s_instr, s_pc;
        logic [7:0]  s_addr;
        int          cyc;
        s_instr = instr;
        s_pc    = instr_pc;
        s_addr  = rom_addr;
        repeat (5) begin
            @(negedge clk);
            checks += 4;
            if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, required 1", instr_valid); end
            if (instr !== s_instr)    begin errors++; $display("FAIL stall_instr: got %0h, required %0h", instr, s_instr); end
            if (instr_pc !== s_pc)    begin errors++; $display("FAIL stall_pc: got %0h, required %0h", instr_pc, s_pc); end
            if (rom_addr !== s_addr)  begin errors++; $display("FAIL stall_addr: got %0h, required %0h", rom_addr, s_addr); end
        end
        push_range(32'd12, 8);
        drain(8, 1'b0, cyc);
    endtask

    task automatic test_redirect();
        int cyc;
        pulse_reset();
        push_range(32'd0, 8);
        drain(8, 1'b1, cyc);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid=%b, required 0", instr_valid); end
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_edge1: got valid=%b, required 0", instr_valid); end
        @(posedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== rom_word(32'h40)) begin
            errors++;
            $display("FAIL redir_edge2: got valid=%b pc=%0h instr=%0h, required 1 pc=40 instr=%0h",
                     instr_valid, instr_pc, instr, rom_word(32'h40));
        end
        push_range(32'h40, 5);
        drain(5, 1'b0, cyc);
    endtask

    task automatic test_wrap();
        int cyc;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd255;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %0h, required 0", rom_addr); end
        push_range(32'd255, 5);
        drain(5, 1'b0, cyc);
    endtask

    task automatic test_midreset();
        int cyc;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre: got valid=%b, required 1", instr_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks += 5;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, required 0", instr_valid); end
        if (instr !== 32'h0)      begin errors++; $display("FAIL mrst_instr: got %0h, required 0", instr); end
        if (instr_pc !== 32'h0)   begin errors++; $display("FAIL mrst_pc: got %0h, required 0", instr_pc); end
        if (rom_addr !== 8'h0)    begin errors++; $display("FAIL mrst_addr: got %0h, required 0", rom_addr); end
        if (finished !== 1'b0)    begin errors++; $display("FAIL mrst_finished: got %b, required 0", finished); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        push_range(32'd0, 4);
        drain(4, 1'b0, cyc);
    endtask

`ifdef IFETCH_HALT_DETECT_EN
    task automatic test_halt();
        int         cyc;
        logic [7:0] s_addr;
        rom_mem[5] = HALT;
        pulse_reset();
        push_range(32'd0, 6);
        drain(6, 1'b1, cyc);
        @(posedge clk); #1;
        s_addr = rom_addr;
        checks += 2;
        if (finished !== 1'b1)    begin errors++; $display("FAIL halt_finished: got %b, required 1", finished); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b, required 0", instr_valid); end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (rom_addr !== s_addr)  begin errors++; $display("FAIL halt_addr: got %0h, required %0h", rom_addr, s_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_redir_valid: got %b, required 0", instr_valid); end
        if (finished !== 1'b1)    begin errors++; $display("FAIL halt_sticky: got %b, required 1", finished); end
        rom_mem[5] = 32'd105;
    endtask
`else
    task automatic test_halt_passthrough();
        int cyc;
        rom_mem[5] = HALT;
        pulse_reset();
        push_range(32'd0, 9);
        drain(9, 1'b0, cyc);
        checks++;
        if (finished !== 1'b0) begin errors++; $display("FAIL pass_finished: got %b, required 0", finished); end
        rom_mem[5] = 32'd105;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'(i + 100);
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_wrap();
        test_midreset();
`ifdef IFETCH_HALT_DETECT_EN
        test_halt();
`else
        test_halt_passthrough();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
